btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 19 +
 rtl/input_sync.sv | 26 ++
 rtl/btn_conditioner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state codes and
// default timing constants for a 50 MHz clock.
package btn_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StReleased  = 3'd0,
    StPressDb   = 3'd1,
    StPressed   = 3'd2,
    StHeld      = 3'd3,
    StReleaseDb = 3'd4
  } btn_state_e;

  localparam int unsigned DefaultDebounceCycles = 1000000;  // 20 ms
  localparam int unsigned DefaultHoldCycles     = 50000000; // 1 s
  localparam int unsigned DefaultRepeatCycles   = 12500000; // 250 ms

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset level.
module input_sync #(
  parameter int unsigned                 WIRE_WIDTH  = 1,
  parameter logic [WIRE_WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIRE_WIDTH-1:0] d_i,
  output logic [WIRE_WIDTH-1:0] q_o
);

  logic [WIRE_WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces one push button and derives press/release pulses, a long-press
// hold level and auto-repeat pulses. All outputs are registered.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned HOLD_CYCLES     = DefaultHoldCycles,
  parameter int unsigned REPEAT_CYCLES   = DefaultRepeatCycles,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              btn_i,
  output logic              level_o,
  output logic              press_o,
  output logic              release_o,
  output logic              hold_o,
  output logic              repeat_o,
  output logic [StateW-1:0] state_o
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HldW = $clog2(HOLD_CYCLES);
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES);

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HldW-1:0] HoldLast = HldW'(HOLD_CYCLES - 1);
  localparam logic [RepW-1:0] RepLast  = RepW'(REPEAT_CYCLES - 1);

  logic btn_sync;
  logic p;

  // Reset the synchronizer to the idle (not-pressed) raw level.
  input_sync #(
    .WIRE_WIDTH  (1),
    .RESET_VALUE (ACTIVE_LOW)
  ) u_input_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (btn_sync)
  );

  assign p = btn_sync ^ ACTIVE_LOW;

  btn_state_e      state_q, state_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [HldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            held_r_q, held_r_d;
  logic            level_q, level_d;
  logic            hold_q, hold_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    held_r_d   = held_r_q;
    level_d    = level_q;
    hold_d     = hold_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;

    unique case (state_q)
      StReleased: begin
        if (p) begin
          state_d  = StPressDb;
          db_cnt_d = '0;
        end
      end
      StPressDb: begin
        if (!p) begin
          state_d = StReleased;
        end else if (db_cnt_q == DbLast) begin
          state_d    = StPressed;
          press_d    = 1'b1;
          level_d    = 1'b1;
          hold_cnt_d = '0;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      StPressed: begin
        if (!p) begin
          state_d  = StReleaseDb;
          db_cnt_d = '0;
          held_r_d = 1'b0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d   = StHeld;
          hold_d    = 1'b1;
          rep_cnt_d = '0;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HldW'(1);
        end
      end
      StHeld: begin
        if (!p) begin
          state_d  = StReleaseDb;
          db_cnt_d = '0;
          held_r_d = 1'b1;
        end else if (rep_cnt_q == RepLast) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else if (rep_cnt_q != '1) begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      StReleaseDb: begin
        // A bounce back to pressed resumes the origin state with its counters intact.
        if (p) begin
          state_d = held_r_q ? StHeld : StPressed;
        end else if (db_cnt_q == DbLast) begin
          state_d   = StReleased;
          release_d = 1'b1;
          level_d   = 1'b0;
          hold_d    = 1'b0;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      default: state_d = StReleased;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StReleased;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      held_r_q   <= 1'b0;
      level_q    <= 1'b0;
      hold_q     <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      held_r_q   <= held_r_d;
      level_q    <= level_d;
      hold_q     <= hold_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
  assign repeat_o  = repeat_q;
  assign state_o   = state_q;

endmodule
